// File: rtl/led_pattern_gen_if.sv
// Control/status bundle for led_pattern_gen: run/mode in, LED bank and strobes out.
// The bright input exists only when LED_PWM_DIM_EN is defined.
interface led_pattern_gen_if #(
  parameter int LED_W = 4,
  parameter int PWM_W = 4
);
  logic             run;
  logic [1:0]       mode;
  logic [LED_W-1:0] LED;
  logic             tick;
  logic             wrap;

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] bright;

  modport master (
    output run,
    output mode,
    output bright,
    input  LED,
    input  tick,
    input  wrap
  );

  modport slave (
    input  run,
    input  mode,
    input  bright,
    output LED,
    output tick,
    output wrap
  );
`else
  modport master (
    output run,
    output mode,
    input  LED,
    input  tick,
    input  wrap
  );

  modport slave (
    input  run,
    input  mode,
    output LED,
    output tick,
    output wrap
  );
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern sequencer: up, down, rotate and ping-pong patterns with tick/wrap strobes.
// Optional brightness PWM gating on the LED outputs is enabled by defining LED_PWM_DIM_EN.
module led_pattern_gen #(
  parameter int LED_W = 4,
  parameter int DIV   = 2,
  parameter int PWM_W = 4
) (
  input  logic             clk_50Mhz,
  input  logic             res,
  led_pattern_gen_if.slave bus
);

  localparam int              PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_ROT  = 2'd2;
  localparam logic [1:0] MODE_PING = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [LED_W-1:0] PAT_ZERO = '0;
  localparam logic [LED_W-1:0] PAT_ONES = '1;
  localparam logic [LED_W-1:0] PAT_BIT0 = LED_W'(1);

  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [LED_W-1:0] pattern_reg, pattern_next;
  logic             dir_reg, dir_next;
  logic [1:0]       mode_q_reg, mode_q_next;
  logic             loaded_reg, loaded_next;
  logic             tick_reg, tick_next;
  logic             wrap_reg, wrap_next;
  logic             step;

  function automatic logic [LED_W-1:0] seed_of(input logic [1:0] m);
    case (m)
      MODE_UP:   return PAT_ZERO;
      MODE_DOWN: return PAT_ONES;
      default:   return PAT_BIT0;
    endcase
  endfunction

  assign step = bus.run && (pre_cnt_reg == PRE_LAST);

  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    pattern_next = pattern_reg;
    dir_next     = dir_reg;
    mode_q_next  = mode_q_reg;
    loaded_next  = loaded_reg;
    tick_next    = step;
    wrap_next    = 1'b0;

    if (bus.run) begin
      pre_cnt_next = step ? '0 : pre_cnt_reg + 1'b1;
    end

    if (step) begin
      // A mode change (or the first step after reset) restarts from the seed.
      if (!loaded_reg || (bus.mode != mode_q_reg)) begin
        pattern_next = seed_of(bus.mode);
        mode_q_next  = bus.mode;
        loaded_next  = 1'b1;
        dir_next     = DIR_LEFT;
      end else begin
        case (mode_q_reg)
          MODE_UP: begin
            pattern_next = pattern_reg + 1'b1;
            wrap_next    = (pattern_reg == PAT_ONES);
          end
          MODE_DOWN: begin
            pattern_next = pattern_reg - 1'b1;
            wrap_next    = (pattern_reg == PAT_ZERO);
          end
          MODE_ROT: begin
            pattern_next = (pattern_reg << 1) | (pattern_reg >> (LED_W - 1));
            wrap_next    = pattern_reg[LED_W-1];
          end
          default: begin
            if (LED_W == 1) begin
              pattern_next = PAT_BIT0;
              wrap_next    = 1'b1;
            end else if (dir_reg == DIR_LEFT) begin
              pattern_next = pattern_reg << 1;
              // Turn around as soon as the MSB is shown so each end lasts one step.
              if (pattern_next[LED_W-1]) begin
                dir_next = DIR_RIGHT;
              end
            end else begin
              pattern_next = pattern_reg >> 1;
              if (pattern_next[0]) begin
                dir_next  = DIR_LEFT;
                wrap_next = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (res) begin
      pre_cnt_reg <= '0;
      pattern_reg <= '0;
      dir_reg     <= DIR_LEFT;
      mode_q_reg  <= MODE_UP;
      loaded_reg  <= 1'b0;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
      pattern_reg <= pattern_next;
      dir_reg     <= dir_next;
      mode_q_reg  <= mode_q_next;
      loaded_reg  <= loaded_next;
      tick_reg    <= tick_next;
      wrap_reg    <= wrap_next;
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] pwm_cnt_reg;
  logic [LED_W-1:0] led_reg;
  logic [LED_W-1:0] led_gated;
  logic             pwm_on;

  // Full-scale brightness is forced on; otherwise lit for bright of every 2^PWM_W clocks.
  assign pwm_on = (bus.bright == '1) || (pwm_cnt_reg < bus.bright);

  generate
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_gate
      assign led_gated[gi] = pattern_reg[gi] & pwm_on;
    end
  endgenerate

  always_ff @(posedge clk_50Mhz) begin
    if (res) begin
      pwm_cnt_reg <= '0;
      led_reg     <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      led_reg     <= led_gated;
    end
  end

  assign bus.LED = led_reg;
`else
  assign bus.LED = pattern_reg;
`endif

  assign bus.tick = tick_reg;
  assign bus.wrap = wrap_reg;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor to the fixed 4-bit LED sequencer. It divides the board clock into a programmable step rate and drives an LED_W-wide LED bank. Four run-time selectable patterns are supported: binary up, binary down, rotate one-hot and ping-pong one-hot. It also provides run/pause control and tick/wrap status strobes. It sits directly behind the board LED pins, sharing the 50 MHz system clock.

Parameters:
LED_W, 4, number of LED outputs; legal range 1..16
DIV, 2, system clocks per pattern step; legal range 1..2^24 (1 = step every clock)
PWM_W, 4, brightness resolution in bits; used only with LED_PWM_DIM_EN

Ports:
clk_50Mhz  input  1  system clock; all logic on its rising edge
res  input  1  synchronous, active-high reset
run  input  1  1 = advance; 0 = pause (prescaler and pattern hold)
mode  input  2  0 up-count, 1 down-count, 2 rotate-left one-hot, 3 ping-pong one-hot
LED  output  LED_W  registered LED drive
tick  output  1  one-cycle strobe on every pattern step
wrap  output  1  one-cycle strobe coincident with tick when the pattern completes a cycle

Behaviour:
- Clock and reset: one clock, clk_50Mhz. Reset is synchronous and active-high on port res. Reset overrides run and mode on the same edge.
- Reset values: LED=0, tick=0, wrap=0, prescaler=0, dir=left, mode_q=0, loaded=0.
- Prescaler: counts 0..DIV-1 while run=1. A step occurs on the cycle the count equals DIV-1, after which the count returns to 0.
- Step strobe: tick=1 for exactly that cycle. LED updates on the same edge tick is registered, so both change together.
- Pause: run=0 freezes the prescaler, LED and dir. tick=wrap=0 while paused. Resuming continues from the held count with no lost or extra step.
- Seed load: on a step where loaded=0 or mode != mode_q, LED loads the seed of the current mode. Same step: mode_q<=mode, loaded<=1, dir<=left, wrap=0.
- Seeds: up=0, down=all-ones, rotate=1, ping-pong=1.
- mode is sampled only on step cycles. Changes between steps are ignored until the next step.
- Mode 0 (up): LED<=LED+1, modulo 2^LED_W. wrap=1 on the step going all-ones->0.
- Mode 1 (down): LED<=LED-1, modulo 2^LED_W. wrap=1 on the step going 0->all-ones.
- Mode 2 (rotate): one-hot bit moves toward MSB. MSB->bit0 asserts wrap.
- Mode 3 (ping-pong), dir=left: shift toward MSB. On reaching the MSB, dir flips to right.
- Mode 3 (ping-pong), dir=right: shift toward bit0. On reaching bit0, dir flips to left and wrap=1.
- Ping-pong sequence for LED_W=4: 1,2,4,8,4,2,1(wrap),2,... Each end position is shown for exactly one step.
- LED_W=1: modes 2/3 hold LED=1 with wrap on every step. Modes 0/1 toggle.
- Reset mid-step or mid-pause: state returns to reset values on the next edge. The first post-reset step reloads the seed.
- Mode 0 sequence after reset, matching the legacy sequencer: 0 (seed), 1, 2, ... 15, 0 (wrap).
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
Macro LED_PWM_DIM_EN, when defined:
- Adds input port bright [PWM_W-1:0] and a free-running PWM_W-bit counter that increments every clock and is cleared by res.
- LED = pattern AND (pwm_cnt < bright), replicated across all bits.
- bright=0 gives LED dark. bright=all-ones is forced fully on.
- Pattern, tick and wrap timing are unaffected.
- The pattern is held in an internal register. LED remains a registered output with one cycle of gating latency.
When not defined:
- No bright port and no PWM counter.
- LED equals the pattern register directly.

Test Plan:
1. LED_W=4, DIV=2, mode=0, run=1, release res. LED steps 0,1,2..15,0 every 2 clocks. tick every 2nd cycle. wrap exactly once, on the 15->0 step.
2. mode=3, LED_W=4, DIV=1. LED=1,2,4,8,4,2,1,2. wrap only on the cycle showing the second 1.
3. Counting in mode 0 at LED=5, switch mode to 1 mid-prescale. Next step LED=15 (seed) with wrap=0, then 14, 13.
4. DIV=3, pause run=0 for 10 cycles at prescaler=1. LED, tick and wrap frozen. After resume, the next step occurs exactly 2 cycles later.
5. Assert res for 1 cycle while in mode 2 with LED=4. Next cycle LED=0, tick=0, wrap=0. The first step loads 1 with no wrap.
6. LED_PWM_DIM_EN defined, PWM_W=4, mode 2 holding, bright=4. Lit LED is high exactly 4 of every 16 cycles. bright=0 gives LED=0 always. bright=15 gives it continuously on.
